// File: rtl/dither_pos_sequencer.sv
// Dither position sequencer: frame/line tracking, noise tile coordinates and a 2-entry result FIFO.
// Optional temporal offset stepping is enabled with `define DITHER_TEMPORAL_EN.
module dither_pos_sequencer #(
  parameter logic [3:0] X_STEP = 4'd5,
  parameter logic [5:0] Y_STEP = 6'd23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sof,
  input  logic        in_sol,
  output logic [31:0] dith_vin,
  output logic [3:0]  dith_x,
  output logic [5:0]  dith_y,
  input  logic [15:0] dith_vout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sof,
  output logic        out_sol
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [1:0]  fifo_count;
  logic        inflight;
  logic        sof_d, sol_d;
  logic [3:0]  x_cnt, x_cur, x_off_cur;
  logic [5:0]  y_cnt, y_cur, y_off_cur;
  logic [17:0] fifo_mem [2];
  logic        rd_ptr, wr_ptr;
  logic        in_frame, accept, issue, push, pop;
  logic [2:0]  occupancy;

  assign in_frame  = (state == RUN) || in_sof;
  assign pop       = out_valid && out_ready;
  assign push      = inflight;
  // A pop in this cycle frees a slot for the beat issued now, sustaining one beat per cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign in_ready  = in_frame ? (occupancy < 3'd2) : 1'b1;
  assign accept    = in_valid && in_ready;
  assign issue     = accept && in_frame;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which would infer a latch.
    state_nxt = state;
    if (state == IDLE && issue) state_nxt = RUN;
  end

  // Coordinates of the beat presented now, before the counters are updated.
  always_comb begin
    x_cur = x_cnt + 4'd1;
    y_cur = y_cnt;
    if (in_sof || in_sol) x_cur = '0;
    if (in_sof)           y_cur = '0;
    else if (in_sol)      y_cur = y_cnt + 6'd1;
  end

`ifdef DITHER_TEMPORAL_EN
  logic [3:0] x_off;
  logic [5:0] y_off;
  logic       sof_seen;

  always_comb begin
    x_off_cur = x_off;
    y_off_cur = y_off;
    if (in_sof && sof_seen) begin
      x_off_cur = x_off + X_STEP;
      y_off_cur = y_off + Y_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_off    <= '0;
      y_off    <= '0;
      sof_seen <= 1'b0;
    end else if (issue && in_sof) begin
      x_off    <= x_off_cur;
      y_off    <= y_off_cur;
      sof_seen <= 1'b1;
    end
  end
`else
  // Offsets are fixed at zero; the masked parameters keep the interface identical in both builds.
  assign x_off_cur = X_STEP & 4'h0;
  assign y_off_cur = Y_STEP & 6'h00;
`endif

  assign dith_vin = in_data;
  assign dith_x   = x_cur + x_off_cur;
  assign dith_y   = y_cur + y_off_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      inflight <= 1'b0;
      sof_d    <= 1'b0;
      sol_d    <= 1'b0;
    end else begin
      inflight <= issue;
      sof_d    <= in_sof;
      sol_d    <= in_sol;
      if (issue) begin
        x_cnt <= x_cur;
        y_cnt <= y_cur;
      end
    end
  end

  // NOTE: FIFO storage is not reset; fifo_count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {dith_vout, sof_d, sol_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr][17:2] : '0;
  assign out_sof   = out_valid && fifo_mem[rd_ptr][1];
  assign out_sol   = out_valid && fifo_mem[rd_ptr][0];

endmodule

// File: tb/tb_dither_pos_sequencer.sv
// Bench for dither_pos_sequencer: stubbed dithering datapath, frame/line reference model and output scoreboard.
module tb_dither_pos_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_sol = 1'b0;
  logic [31:0] dith_vin;
  logic [3:0]  dith_x;
  logic [5:0]  dith_y;
  logic [15:0] dith_vout = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sof;
  logic        out_sol;

  dither_pos_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_sol(in_sol),
    .dith_vin(dith_vin), .dith_x(dith_x), .dith_y(dith_y), .dith_vout(dith_vout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_sol(out_sol)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] dp_f(logic [31:0] v, logic [3:0] x, logic [5:0] y);
    return (v[31:16] ^ v[15:0]) ^ {x, 6'd0, y} ^ {y, 6'd0, x};
  endfunction

  // Stand-in dithering datapath: result valid one cycle after the coordinates are presented.
  always @(posedge clk) dith_vout <= dp_f(dith_vin, dith_x, dith_y);

  // Reference model state
  bit          m_started;
  int          m_nsof, m_x, m_y, m_xo, m_yo;
  logic [17:0] exp_q[$];
  logic [3:0]  last_x;
  logic [5:0]  last_y;
  int          n_acc = 0;
  int          stall_cycles = 0;
  bit          hold_valid;
  logic [17:0] hold_val;
  bit          rnd_on;

  function automatic void model_clear();
    m_started = 0; m_nsof = 0; m_x = 0; m_y = 0; m_xo = 0; m_yo = 0;
    exp_q.delete();
    hold_valid = 0;
  endfunction

  function automatic void model_accept();
    int ex, ey;
    n_acc++;
    if (!m_started && !in_sof) return;
    m_started = 1;
    if (in_sof) begin
      m_nsof++;
`ifdef DITHER_TEMPORAL_EN
      if (m_nsof > 1) begin
        m_xo = (m_xo + 5) % 16;
        m_yo = (m_yo + 23) % 64;
      end
`endif
      m_x = 0;
      m_y = 0;
    end else if (in_sol) begin
      m_x = 0;
      m_y = (m_y + 1) % 64;
    end else begin
      m_x = (m_x + 1) % 16;
    end
    ex = (m_x + m_xo) % 16;
    ey = (m_y + m_yo) % 64;
    vectors++;
    if (dith_x !== 4'(ex) || dith_y !== 6'(ey)) begin
      miscompares++;
      $display("FAIL coords got x=%0d y=%0d exp x=%0d y=%0d", dith_x, dith_y, ex, ey);
    end
    last_x = dith_x;
    last_y = dith_y;
    exp_q.push_back({dp_f(in_data, 4'(ex), 6'(ey)), in_sof, in_sol});
  endfunction

  // Monitor: accepted beats feed the model, popped results are scoreboarded, stalled heads must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_valid) begin
        vectors++;
        if (!out_valid || {out_data, out_sof, out_sol} !== hold_val) begin
          miscompares++;
          $display("FAIL out_hold got v=%b %h exp %h", out_valid, {out_data, out_sof, out_sol}, hold_val);
        end
      end
      hold_valid = out_valid && !out_ready;
      hold_val   = {out_data, out_sof, out_sol};
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL out_unexpected got %h exp none", {out_data, out_sof, out_sol});
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          if ({out_data, out_sof, out_sol} !== e) begin
            miscompares++;
            $display("FAIL out_data got %h exp %h", {out_data, out_sof, out_sol}, e);
          end
        end
      end
      if (in_valid && in_ready) model_accept();
    end
  end

  task automatic send(input bit sof, input bit sol, input logic [31:0] d);
    bit done = 0;
    in_valid = 1; in_sof = sof; in_sol = sol; in_data = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else stall_cycles++;
      @(posedge clk); #1;
    end
    in_valid = 0; in_sof = 0; in_sol = 0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout got in_ready=0 exp 1 within 200 cycles");
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0 || out_valid) begin
      miscompares++;
      $display("FAIL drain got pending=%0d out_valid=%b exp 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1; in_valid = 0; in_sof = 0; in_sol = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1; in_valid = 0; in_sof = 0; in_sol = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 0 || out_data !== 16'h0 || out_sof !== 0 || out_sol !== 0 || in_ready !== 1) begin
      miscompares++;
      $display("FAIL reset got v=%b d=%h sof=%b sol=%b rdy=%b exp 0/0000/0/0/1",
               out_valid, out_data, out_sof, out_sol, in_ready);
    end
    rst = 0;
  endtask

  task automatic test_discard_until_sof();
    int acc0;
    apply_reset();
    out_ready = 0;
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) send(0, i == 1, $urandom);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (n_acc - acc0 != 3 || out_valid !== 0) begin
      miscompares++;
      $display("FAIL idle_discard got acc=%0d out_valid=%b exp 3/0", n_acc - acc0, out_valid);
    end
    send(1, 0, $urandom);
    vectors++;
    if (out_valid !== 0) begin
      miscompares++;
      $display("FAIL sof_latency1 got out_valid=%b exp 0", out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1 || out_sof !== 1) begin
      miscompares++;
      $display("FAIL sof_latency2 got v=%b sof=%b exp 1/1", out_valid, out_sof);
    end
    drain();
  endtask

  task automatic test_line();
    int s0;
    out_ready = 1;
    s0 = stall_cycles;
    send(0, 1, $urandom);
    for (int i = 1; i < 20; i++) send(0, 0, $urandom);
    vectors++;
    if (stall_cycles != s0 || last_x !== 4'((3 + m_xo) % 16)) begin
      miscompares++;
      $display("FAIL line_rate got stalls=%0d last_x=%0d exp 0/%0d", stall_cycles - s0, last_x, (3 + m_xo) % 16);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    vectors++;
    if (acc != 2 || out_valid !== 1 || exp_q.size() != 2) begin
      miscompares++;
      $display("FAIL backpressure got acc=%0d v=%b pending=%0d exp 2/1/2", acc, out_valid, exp_q.size());
    end
    drain();
  endtask

  task automatic test_y_wrap();
    out_ready = 1;
    send(1, 0, $urandom);
    send(0, 0, $urandom);
    for (int l = 1; l <= 64; l++) begin
      send(0, 1, $urandom);
      if (l == 63) begin
        vectors++;
        if (last_y !== 6'((63 + m_yo) % 64)) begin
          miscompares++;
          $display("FAIL y_line63 got %0d exp %0d", last_y, (63 + m_yo) % 64);
        end
      end
      if (l == 64) begin
        vectors++;
        if (last_y !== 6'(m_yo)) begin
          miscompares++;
          $display("FAIL y_wrap got %0d exp %0d", last_y, m_yo);
        end
      end
      send(0, 0, $urandom);
    end
    drain();
  endtask

  task automatic test_frames();
`ifdef DITHER_TEMPORAL_EN
    int ex[3] = '{0, 5, 10};
    int ey[3] = '{0, 23, 46};
`else
    int ex[3] = '{0, 0, 0};
    int ey[3] = '{0, 0, 0};
`endif
    apply_reset();
    out_ready = 1;
    for (int f = 0; f < 3; f++) begin
      send(1, 0, $urandom);
      vectors++;
      if (last_x !== 4'(ex[f]) || last_y !== 6'(ey[f])) begin
        miscompares++;
        $display("FAIL frame%0d_start got %0d/%0d exp %0d/%0d", f, last_x, last_y, ex[f], ey[f]);
      end
      send(0, 0, $urandom);
      send(0, 1, $urandom);
      send(0, 0, $urandom);
    end
    drain();
  endtask

  task automatic test_random();
    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send($urandom_range(39) == 0, $urandom_range(7) == 0, $urandom);
          repeat ($urandom_range(2)) @(posedge clk);
          #1;
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          out_ready = ($urandom_range(2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_midframe();
    out_ready = 0;
    send(1, 0, $urandom);
    send(0, 0, $urandom);
    rst = 1;
    model_clear();
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 0 || out_data !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_flush got v=%b d=%h exp 0/0000", out_valid, out_data);
    end
    rst = 0;
    out_ready = 1;
    send(0, 1, $urandom);
    send(0, 0, $urandom);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 0) begin
      miscompares++;
      $display("FAIL rst_stale got out_valid=%b exp 0", out_valid);
    end
    send(1, 0, $urandom);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_discard_until_sof();
    test_line();
    test_backpressure();
    test_y_wrap();
    test_frames();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
